// File: rtl/sign_narrower_if.sv
// Producer/consumer bundle for sign_narrower: 32-bit word in, narrowed halfword and overflow status out.
interface sign_narrower_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic             out_ovf;
    logic [CNT_W-1:0] ovf_count;
    logic             sticky_ovf;
    logic             clear;

    modport master (
        output in_valid, in, out_ready, clear,
        input  in_ready, out_valid, out, out_ovf, ovf_count, sticky_ovf
    );

    modport slave (
        input  in_valid, in, out_ready, clear,
        output in_ready, out_valid, out, out_ovf, ovf_count, sticky_ovf
    );
endinterface

// File: rtl/sign_narrower.sv
// Narrows signed IN_W words to OUT_W halfwords, flags non-sign-extended words; SIGN_NARROWER_SATURATE_EN clamps them.
// Latency: one cycle from accept to out_valid when empty; one word per cycle sustained.
// Backpressure: 2-entry buffer, in_ready = occupancy < 2, decoded only from registered state.
module sign_narrower #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    sign_narrower_if.slave bus
);
    typedef struct packed {
        logic             ovf;
        logic [OUT_W-1:0] dat;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t             head_q;
    entry_t             spare_q;
    entry_t             new_entry;
    logic               head_vld_q;
    logic               spare_vld_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sticky_q;
    logic               acc;
    logic               rel;
    logic [IN_W-OUT_W:0] upper;

    // A word fits when everything from the halfword sign bit upward is a copy of that bit.
    assign upper = bus.in[IN_W-1:OUT_W-1];

    always_comb begin
        new_entry     = '0;
        new_entry.ovf = !((&upper) || !(|upper));
`ifdef SIGN_NARROWER_SATURATE_EN
        if (new_entry.ovf) begin
            new_entry.dat = bus.in[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                           : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            new_entry.dat = bus.in[OUT_W-1:0];
        end
`else
        new_entry.dat = bus.in[OUT_W-1:0];
`endif
    end

    // The spare slot is only ever occupied while the head is, so it alone means "full".
    assign bus.in_ready   = !spare_vld_q;
    assign acc            = bus.in_valid && !spare_vld_q;
    assign rel            = head_vld_q && bus.out_ready;

    assign bus.out_valid  = head_vld_q;
    assign bus.out        = head_q.dat;
    assign bus.out_ovf    = head_q.ovf;
    assign bus.ovf_count  = cnt_q;
    assign bus.sticky_ovf = sticky_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q      <= '0;
            spare_q     <= '0;
            head_vld_q  <= 1'b0;
            spare_vld_q <= 1'b0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            if (!head_vld_q) begin
                if (acc) begin
                    head_q     <= new_entry;
                    head_vld_q <= 1'b1;
                end
            end else if (spare_vld_q) begin
                if (rel) begin
                    head_q      <= spare_q;
                    spare_vld_q <= 1'b0;
                end
            end else begin
                // Head data is left in place on a plain release so out holds its last value.
                if (rel && acc) begin
                    head_q <= new_entry;
                end else if (rel) begin
                    head_vld_q <= 1'b0;
                end else if (acc) begin
                    spare_q     <= new_entry;
                    spare_vld_q <= 1'b1;
                end
            end

            if (acc && new_entry.ovf) begin
                if (bus.clear) begin
                    cnt_q <= CNT_W'(1);
                end else if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                sticky_q <= 1'b1;
            end else if (bus.clear) begin
                cnt_q    <= '0;
                sticky_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sign_narrower.sv
// Self-checking bench for sign_narrower: vector table, directed corner sequences and random traffic vs a queue model.
module tb_sign_narrower;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    sign_narrower_if #(.IN_W(32), .OUT_W(16), .CNT_W(8)) bus ();

    sign_narrower #(.IN_W(32), .OUT_W(16), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [15:0] dat;
        logic        ovf;
    } ent_t;

    typedef struct {
        logic [31:0] in;
        logic [15:0] exp_sat;
        logic [15:0] exp_trunc;
        logic        exp_ovf;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    ent_t        mq[$];
    logic [15:0] obs[$];
    int          m_cnt;
    bit          m_sticky;
    ent_t        last;

    function automatic ent_t ref_narrow(input logic [31:0] w);
        longint v;
        ent_t   e;
        v     = longint'($signed(w));
        e.ovf = (v > 32767) || (v < -32768);
`ifdef SIGN_NARROWER_SATURATE_EN
        if (v > 32767)       e.dat = 16'h7fff;
        else if (v < -32768) e.dat = 16'h8000;
        else                 e.dat = w[15:0];
`else
        e.dat = w[15:0];
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock: predict from pre-edge inputs, advance the model, compare after the edge.
    task automatic cycle();
        bit   acc;
        bit   rel;
        bit   clr;
        bit   rst;
        ent_t ne;
        rst = reset;
        if (!rst) chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < 2));
        acc = bus.in_valid && (mq.size() < 2);
        rel = bus.out_ready && (mq.size() > 0);
        clr = bus.clear;
        ne  = ref_narrow(bus.in);
        if (!rst && bus.out_valid && bus.out_ready) obs.push_back(bus.out);
        @(posedge clock);
        #1;
        cyc++;
        if (rst) begin
            mq.delete();
            m_cnt    = 0;
            m_sticky = 1'b0;
            last.dat = 16'h0;
            last.ovf = 1'b0;
        end else begin
            if (rel) void'(mq.pop_front());
            if (acc) mq.push_back(ne);
            if (acc && ne.ovf) begin
                m_cnt    = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
                m_sticky = 1'b1;
            end else if (clr) begin
                m_cnt    = 0;
                m_sticky = 1'b0;
            end
            if (mq.size() > 0) last = mq[0];
        end
        chk("out_valid",  32'(bus.out_valid),  32'(mq.size() > 0));
        chk("out",        32'(bus.out),        32'(last.dat));
        chk("out_ovf",    32'(bus.out_ovf),    32'(last.ovf));
        chk("ovf_count",  32'(bus.ovf_count),  32'(m_cnt));
        chk("sticky_ovf", 32'(bus.sticky_ovf), 32'(m_sticky));
    endtask

    vec_t tbl[9];

    initial begin
        logic [15:0] h;
        int          lows;

        tbl[0] = '{32'h00007fff, 16'h7fff, 16'h7fff, 1'b0};
        tbl[1] = '{32'hffff8000, 16'h8000, 16'h8000, 1'b0};
        tbl[2] = '{32'h00000000, 16'h0000, 16'h0000, 1'b0};
        tbl[3] = '{32'h00008000, 16'h7fff, 16'h8000, 1'b1};
        tbl[4] = '{32'h80000000, 16'h8000, 16'h0000, 1'b1};
        tbl[5] = '{32'hffff7fff, 16'h8000, 16'h7fff, 1'b1};
        tbl[6] = '{32'h00001234, 16'h1234, 16'h1234, 1'b0};
        tbl[7] = '{32'hffffffff, 16'hffff, 16'hffff, 1'b0};
        tbl[8] = '{32'h7fffffff, 16'h7fff, 16'hffff, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in        = 32'h0;
        bus.out_ready = 1'b0;
        bus.clear     = 1'b0;
        reset         = 1'b1;
        m_cnt         = 0;
        m_sticky      = 1'b0;
        last.dat      = 16'h0;
        last.ovf      = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.ovf_count), 32'd0);

        // Vector table, streaming with the consumer always ready.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.in = tbl[i].in;
            cycle();
            chk("tbl_vld", 32'(bus.out_valid), 32'd1);
`ifdef SIGN_NARROWER_SATURATE_EN
            chk("tbl_out", 32'(bus.out), 32'(tbl[i].exp_sat));
`else
            chk("tbl_out", 32'(bus.out), 32'(tbl[i].exp_trunc));
`endif
            chk("tbl_ovf", 32'(bus.out_ovf), 32'(tbl[i].exp_ovf));
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("tbl_count", 32'(bus.ovf_count), 32'd4);
        chk("tbl_sticky", 32'(bus.sticky_ovf), 32'd1);
        chk("hold_vld", 32'(bus.out_valid), 32'd0);
        bus.clear = 1'b1;
        cycle();
        bus.clear = 1'b0;
        chk("clr_count", 32'(bus.ovf_count), 32'd0);

        // Backpressure: A, B fill the buffer, C waits, then everything drains in order.
        obs.delete();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 32'h00000011;
        cycle();
        bus.in        = 32'hffff8001;
        cycle();
        chk("bp_full", 32'(bus.in_ready), 32'd0);
        bus.in        = 32'h00000c0c;
        cycle();
        cycle();
        cycle();
        bus.out_ready = 1'b1;
        cycle();
        chk("bp_reopen", 32'(bus.in_ready), 32'd1);
        cycle();
        bus.in_valid  = 1'b0;
        cycle();
        cycle();
        chk("bp_count", 32'(obs.size()), 32'd3);
        if (obs.size() == 3) begin
            chk("bp_a", 32'(obs[0]), 32'h0011);
            chk("bp_b", 32'(obs[1]), 32'h8001);
            chk("bp_c", 32'(obs[2]), 32'h0c0c);
        end

        // Counter saturation, then clear, then clear racing an overflowing accept.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.in = 32'h00010000 + 32'(i);
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("sat_count", 32'(bus.ovf_count), 32'd255);
        bus.clear = 1'b1;
        cycle();
        chk("clear_count", 32'(bus.ovf_count), 32'd0);
        chk("clear_sticky", 32'(bus.sticky_ovf), 32'd0);
        bus.in_valid = 1'b1;
        bus.in       = 32'h80000000;
        cycle();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        chk("race_count", 32'(bus.ovf_count), 32'd1);
        chk("race_sticky", 32'(bus.sticky_ovf), 32'd1);
        cycle();

        // Continuous stream: one output per cycle, never full.
        obs.delete();
        lows         = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in = 32'h00000100 + 32'(i);
            if (!bus.in_ready) lows++;
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        chk("stream_never_full", 32'(lows), 32'd0);
        chk("stream_count", 32'(obs.size()), 32'd10);
        for (int i = 0; i < obs.size(); i++) chk("stream_order", 32'(obs[i]), 32'h0100 + 32'(i));

        // Reset with two entries in flight and ovf_count=5.
        bus.clear = 1'b1;
        cycle();
        bus.clear    = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in = 32'h00020000 + 32'(i);
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 32'hfff00000;
        cycle();
        bus.in        = 32'h00300000;
        cycle();
        chk("pre_rst_count", 32'(bus.ovf_count), 32'd5);
        chk("pre_rst_full", 32'(bus.in_ready), 32'd0);
        reset  = 1'b1;
        bus.in = 32'h00005a5a;
        cycle();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        chk("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out", 32'(bus.out), 32'd0);
        chk("mid_rst_count", 32'(bus.ovf_count), 32'd0);
        chk("mid_rst_sticky", 32'(bus.sticky_ovf), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        obs.delete();
        bus.out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        chk("rst_dropped", 32'(obs.size()), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.clear     = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0: begin
                    h      = 16'($urandom);
                    bus.in = {{16{h[15]}}, h};
                end
                1: bus.in = 32'h00007fff + 32'($urandom_range(0, 2));
                2: bus.in = 32'hffff7fff + 32'($urandom_range(0, 2));
                default: bus.in = $urandom;
            endcase
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sign_narrower.md
# sign_narrower

Inverse of the datapath sign extender: accepts 32-bit signed words and narrows them to 16-bit signed halfwords, flagging any word that is not a valid sign extension of its low 16 bits. It sits between the ALU result path and halfword store logic (sh / 16-bit immediate re-encoding). A 2-entry buffer with valid/ready handshakes on both sides decouples producer and consumer. A saturating overflow counter and a sticky flag are provided for status reporting.

## Interface
- IN_W, 32, input word width
- OUT_W, 16, output halfword width
- CNT_W, 8, overflow counter width
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer presents a word on in
- in_ready  output  1  buffer can accept; equals (occupancy < 2)
- in  input  IN_W  signed word to narrow
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head
- out  output  OUT_W  narrowed halfword at head
- out_ovf  output  1  head word did not fit in OUT_W signed
- ovf_count  output  CNT_W  saturating count of accepted overflowing words
- sticky_ovf  output  1  set on any accepted overflowing word, held until cleared
- clear  input  1  synchronous clear of ovf_count and sticky_ovf

## Operation
- Overflow test: ovf = NOT (in[IN_W-1:OUT_W-1] all 0s or all 1s); e.g. 0x00007FFF and 0xFFFF8000 fit, 0x00008000 does not.
- Narrowing: when ovf=0, out = in[OUT_W-1:0]. When ovf=1, behaviour per Configuration.
- Narrowing and ovf are computed at accept time and stored with the entry (OUT_W+1 bits per entry).
- Accept: in_valid & in_ready on a rising edge writes the entry at the tail.
- Release: out_valid & out_ready on a rising edge pops the head.
- Buffer: 2-entry FIFO, occupancy 0..2, in order.
  - Occupancy 0: in_ready=1, out_valid=0.
  - Occupancy 1: in_ready=1, out_valid=1. Simultaneous accept and release keeps occupancy at 1, and the new word becomes the head.
  - Occupancy 2: in_ready=0. A release frees one slot; in_ready rises the next cycle.
- While out_valid=0, out and out_ovf hold their last values (0 after reset).
- Counter: increments on each accepted word with ovf=1 and saturates at 2^CNT_W-1 (255); it never wraps. sticky_ovf sets on the same event.
- clear: the next edge forces ovf_count=0 and sticky_ovf=0. If an overflowing accept happens in the same cycle, the result is ovf_count=1 and sticky_ovf=1 (the accept wins over the clear).
- Reset: all state clears regardless of other inputs. Words presented while reset=1 are dropped. Entries in flight are discarded.

## Timing
- Reset values: out_valid=0, out=0, out_ovf=0, ovf_count=0, sticky_ovf=0, occupancy=0. in_ready=1 from the first cycle after reset deasserts.
- Latency: a word accepted at edge N appears at out with out_valid=1 after edge N (one cycle) when the buffer was empty.
- Throughput: one word per cycle when out_ready is held high.
- All outputs are registered except in_ready, which is decoded combinationally from the occupancy register. There is no combinational path from in or out_ready to any output.
- ovf_count and sticky_ovf update on the same edge as the accept.

## Configuration
- SIGN_NARROWER_SATURATE_EN defined:
  - overflowing positive words clamp to 0x7FFF;
  - overflowing negative words (in[IN_W-1]=1) clamp to 0x8000.
- SIGN_NARROWER_SATURATE_EN undefined: overflowing words truncate to in[OUT_W-1:0].
- out_ovf, ovf_count and sticky_ovf behave identically in both builds.

## Test plan
- In-range words: out_ready=1; push 0x00007FFF, 0xFFFF8000, 0x00000000 -> outputs 0x7FFF, 0x8000, 0x0000, each with out_ovf=0, one cycle after accept. ovf_count stays 0.
- Overflowing words: push 0x00008000 and 0x80000000.
  - Saturate build: 0x7FFF then 0x8000.
  - Truncate build: 0x8000 then 0x0000.
  - Both builds: out_ovf=1 on each, ovf_count=2, sticky_ovf=1.
- Backpressure: hold out_ready=0 and push A, B, C.
  - in_ready drops after B; C is held by the producer.
  - Raise out_ready: A, B, C drain in order, with no loss or duplication.
- Counter saturation and clear:
  - 300 overflowing words -> ovf_count=255.
  - clear alone -> 0.
  - clear together with an overflowing accept -> ovf_count=1, sticky_ovf=1.
- Simultaneous accept/release at occupancy 1 with a continuous stream of 10 words -> one output per cycle and occupancy never reaches 2.
- Reset mid-operation: with 2 entries buffered and ovf_count=5, assert reset for one cycle.
  - Next cycle: out_valid=0, out=0, ovf_count=0, sticky_ovf=0, in_ready=1.
  - A word presented during reset never appears at out.
